alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares one combinational RV32I ALU between two requesters, e.g. an integer issue port and a branch/address-generation port.
- Each requester has a valid/ready request channel and a valid/ready response channel.
- Arbitrates between requesters, registers the winning operation into the ALU input registers, and captures alu_out/alubranch.
- Returns the result to the requester that owns it.

Parameters:
- DATA_W, 32, operand/result width; must match the ALU (32).
- FAIR, 1, 1 = round-robin arbitration; 0 = fixed priority with req0 highest.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- reqN_valid  in  1  (N=0,1) request valid.
- reqN_ready  out  1  request accepted this cycle when valid&ready.
- reqN_opcode  in  5  instr[6:2] opcode.
- reqN_func3  in  3  func3.
- reqN_func7  in  1  instr[30].
- reqN_op1  in  DATA_W  operand1.
- reqN_op2  in  DATA_W  operand2.
- alu_opcode  out  5  registered opcode to ALU.
- alu_func3  out  3  registered func3 to ALU.
- alu_func7  out  1  registered func7 to ALU.
- alu_op1  out  DATA_W  registered operand1 to ALU.
- alu_op2  out  DATA_W  registered operand2 to ALU.
- alu_result  in  DATA_W  ALU alu_out.
- alu_branch  in  1  ALU alubranch.
- rspN_valid  out  1  (N=0,1) response valid.
- rspN_ready  in  1  response consumed when valid&ready.
- rspN_data  out  DATA_W  captured alu_out.
- rspN_branch  out  1  captured alubranch.

Behaviour:
- Reset (rst_n low, async) sets:
  - state=IDLE, owner=0.
  - last_grant=1, so req0 wins the first tie.
  - All alu_* outputs = 0.
  - rspN_valid=0, rspN_data=0, rspN_branch=0.
- reqN_ready = (state==IDLE) && winner==N, combinational. It is 1 for the winner even if its valid is low only when that requester is the sole candidate; otherwise 0.
- Winner selection in IDLE:
  - Only one reqN_valid → that N.
  - Both valid, FAIR=1 → !last_grant.
  - Both valid, FAIR=0 → 0.
- FSM IDLE → EXEC → RESP → IDLE:
  - IDLE: on handshake of winner W (cycle T), latch W's opcode/func3/func7/op1/op2 into alu_* registers, set owner=W, update last_grant=W, go to EXEC.
  - EXEC (T+1): ALU evaluates the registered inputs. At the clock edge, capture alu_result/alu_branch into rsp{owner}_data/_branch, set rsp{owner}_valid=1, go to RESP.
  - RESP (T+2 onward): hold rsp valid/data/branch stable until rsp{owner}_ready=1. Then clear valid and return to IDLE. The non-owner rsp_valid stays 0.
- Latency: request handshake at T → response valid at T+2. Throughput is 1 op per 3 cycles with zero backpressure.
- Backpressure: in RESP, both reqN_ready=0. No new request is accepted until the response is consumed.
- The rsp data register of the non-owner keeps its last value. Only valid qualifies data.
- Requesters must hold valid and payload until ready. Deasserting valid before ready is legal; nothing is latched.
- The block never inspects opcode. All RV32I encodings pass through; results are whatever the ALU produces.
- Reset mid EXEC/RESP: the in-flight op is discarded, no response is issued, and last_grant returns to 1.

Optional Feature:
- Macro: ALU_ARB_BYPASS_EN.
- Defined:
  - EXEC state is removed.
  - In IDLE, alu_* are driven combinationally from the selected request (mux, not registers). Outside IDLE they are held at the latched values.
  - alu_result/alu_branch are captured at handshake cycle T.
  - rsp valid at T+1; throughput 1 op per 2 cycles.
  - alu_* reset values apply only to the latch.
- Undefined: registered 3-state FSM as above, latency 2.

Test Plan:
- req0 only, opcode=01100 func3=000 func7=0 op1=5 op2=7 → req0_ready=1 at T, rsp0_valid at T+2 with data=12, branch=0; rsp1_valid stays 0.
- Both valid every cycle with responses always ready, FAIR=1 → grants req0, req1, req0, req1 (first after reset = req0); each response returns to the correct port.
- req1 opcode=11000 func3=100 op1=0xFFFFFFFF op2=1 → rsp1_branch=1 (blt signed). Same with func3=110 (bltu) → branch=0.
- rsp1_ready held low 4 cycles after rsp1_valid → rsp1_valid/data stable, req0_ready=0 throughout, req0 accepted only the cycle after rsp1 handshake returns to IDLE.
- rst_n pulsed low during EXEC → rsp0/rsp1 valid never assert for that op; after release reqN_ready available in IDLE and the next tie grants req0.
- FAIR=0, both valid continuously for 3 ops → req0 granted all 3; req1 granted only once req0_valid drops.

Source files
------------

// File: rtl/alu_share_arbiter_if.sv
// Bundle for alu_share_arbiter: two request channels, two response channels, and the shared ALU port.
// master = requesters plus ALU side, slave = the arbiter.
interface alu_share_arbiter_if #(
    parameter int unsigned DATA_W = 32
);
    logic              req0_valid;
    logic              req0_ready;
    logic [4:0]        req0_opcode;
    logic [2:0]        req0_func3;
    logic              req0_func7;
    logic [DATA_W-1:0] req0_op1;
    logic [DATA_W-1:0] req0_op2;
    logic              req1_valid;
    logic              req1_ready;
    logic [4:0]        req1_opcode;
    logic [2:0]        req1_func3;
    logic              req1_func7;
    logic [DATA_W-1:0] req1_op1;
    logic [DATA_W-1:0] req1_op2;

    logic [4:0]        alu_opcode;
    logic [2:0]        alu_func3;
    logic              alu_func7;
    logic [DATA_W-1:0] alu_op1;
    logic [DATA_W-1:0] alu_op2;
    logic [DATA_W-1:0] alu_result;
    logic              alu_branch;

    logic              rsp0_valid;
    logic              rsp0_ready;
    logic [DATA_W-1:0] rsp0_data;
    logic              rsp0_branch;
    logic              rsp1_valid;
    logic              rsp1_ready;
    logic [DATA_W-1:0] rsp1_data;
    logic              rsp1_branch;

    modport master (
        output req0_valid, req0_opcode, req0_func3, req0_func7, req0_op1, req0_op2,
        output req1_valid, req1_opcode, req1_func3, req1_func7, req1_op1, req1_op2,
        input  req0_ready, req1_ready,
        input  alu_opcode, alu_func3, alu_func7, alu_op1, alu_op2,
        output alu_result, alu_branch,
        input  rsp0_valid, rsp0_data, rsp0_branch, rsp1_valid, rsp1_data, rsp1_branch,
        output rsp0_ready, rsp1_ready
    );

    modport slave (
        input  req0_valid, req0_opcode, req0_func3, req0_func7, req0_op1, req0_op2,
        input  req1_valid, req1_opcode, req1_func3, req1_func7, req1_op1, req1_op2,
        output req0_ready, req1_ready,
        output alu_opcode, alu_func3, alu_func7, alu_op1, alu_op2,
        input  alu_result, alu_branch,
        output rsp0_valid, rsp0_data, rsp0_branch, rsp1_valid, rsp1_data, rsp1_branch,
        input  rsp0_ready, rsp1_ready
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Shares one combinational RV32I ALU between two valid/ready requesters (IDLE -> EXEC -> RESP).
// Define ALU_ARB_BYPASS_EN to drive the ALU from the winning request in IDLE and drop EXEC.
module alu_share_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter bit          FAIR   = 1'b1
) (
    input logic                clk,
    input logic                rst_n,
    alu_share_arbiter_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

`ifdef ALU_ARB_BYPASS_EN
    localparam state_e StAfterIdle = StResp;
`else
    localparam state_e StAfterIdle = StExec;
`endif

    state_e            r_state;
    logic              r_owner;
    logic              r_last_grant;
    logic [4:0]        r_alu_opcode;
    logic [2:0]        r_alu_func3;
    logic              r_alu_func7;
    logic [DATA_W-1:0] r_alu_op1;
    logic [DATA_W-1:0] r_alu_op2;
    logic [1:0]        r_rsp_valid;
    logic [1:0]        r_rsp_branch;
    logic [DATA_W-1:0] r_rsp_data0;
    logic [DATA_W-1:0] r_rsp_data1;

    logic              w_idle;
    logic              w_win;
    logic              w_hs;
    logic              w_rsp_done;
    logic              w_cap;
    logic              w_cap_idx;
    logic [4:0]        w_sel_opcode;
    logic [2:0]        w_sel_func3;
    logic              w_sel_func7;
    logic [DATA_W-1:0] w_sel_op1;
    logic [DATA_W-1:0] w_sel_op2;

    // With no request pending the winner defaults to req0.
    always_comb begin
        if (bus.req0_valid && bus.req1_valid) begin
            w_win = FAIR ? ~r_last_grant : 1'b0;
        end else begin
            w_win = bus.req1_valid;
        end
    end

    assign w_idle       = (r_state == StIdle);
    assign w_hs         = w_idle && (w_win ? bus.req1_valid : bus.req0_valid);
    assign w_rsp_done   = r_owner ? bus.rsp1_ready : bus.rsp0_ready;
    assign w_sel_opcode = w_win ? bus.req1_opcode : bus.req0_opcode;
    assign w_sel_func3  = w_win ? bus.req1_func3  : bus.req0_func3;
    assign w_sel_func7  = w_win ? bus.req1_func7  : bus.req0_func7;
    assign w_sel_op1    = w_win ? bus.req1_op1    : bus.req0_op1;
    assign w_sel_op2    = w_win ? bus.req1_op2    : bus.req0_op2;

    assign bus.req0_ready = w_idle && !w_win;
    assign bus.req1_ready = w_idle && w_win;

`ifdef ALU_ARB_BYPASS_EN
    assign bus.alu_opcode = w_idle ? w_sel_opcode : r_alu_opcode;
    assign bus.alu_func3  = w_idle ? w_sel_func3  : r_alu_func3;
    assign bus.alu_func7  = w_idle ? w_sel_func7  : r_alu_func7;
    assign bus.alu_op1    = w_idle ? w_sel_op1    : r_alu_op1;
    assign bus.alu_op2    = w_idle ? w_sel_op2    : r_alu_op2;
    assign w_cap          = w_hs;
    assign w_cap_idx      = w_win;
`else
    assign bus.alu_opcode = r_alu_opcode;
    assign bus.alu_func3  = r_alu_func3;
    assign bus.alu_func7  = r_alu_func7;
    assign bus.alu_op1    = r_alu_op1;
    assign bus.alu_op2    = r_alu_op2;
    assign w_cap          = (r_state == StExec);
    assign w_cap_idx      = r_owner;
`endif

    assign bus.rsp0_valid  = r_rsp_valid[0];
    assign bus.rsp1_valid  = r_rsp_valid[1];
    assign bus.rsp0_data   = r_rsp_data0;
    assign bus.rsp1_data   = r_rsp_data1;
    assign bus.rsp0_branch = r_rsp_branch[0];
    assign bus.rsp1_branch = r_rsp_branch[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_alu_opcode <= '0;
            r_alu_func3  <= '0;
            r_alu_func7  <= 1'b0;
            r_alu_op1    <= '0;
            r_alu_op2    <= '0;
            r_rsp_valid  <= '0;
            r_rsp_branch <= '0;
            r_rsp_data0  <= '0;
            r_rsp_data1  <= '0;
        end else begin
            // Only the owner's response slot is written; the other keeps its old data.
            if (w_cap) begin
                if (w_cap_idx) begin
                    r_rsp_data1     <= bus.alu_result;
                    r_rsp_branch[1] <= bus.alu_branch;
                    r_rsp_valid     <= 2'b10;
                end else begin
                    r_rsp_data0     <= bus.alu_result;
                    r_rsp_branch[0] <= bus.alu_branch;
                    r_rsp_valid     <= 2'b01;
                end
            end
            unique case (r_state)
                StIdle: begin
                    if (w_hs) begin
                        r_alu_opcode <= w_sel_opcode;
                        r_alu_func3  <= w_sel_func3;
                        r_alu_func7  <= w_sel_func7;
                        r_alu_op1    <= w_sel_op1;
                        r_alu_op2    <= w_sel_op2;
                        r_owner      <= w_win;
                        r_last_grant <= w_win;
                        r_state      <= StAfterIdle;
                    end
                end
                StExec: r_state <= StResp;
                StResp: begin
                    if (w_rsp_done) begin
                        r_rsp_valid <= '0;
                        r_state     <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: one round-robin and one fixed-priority instance,
// a behavioural RV32I ALU, and per-scenario tasks compared against a reference model.
`timescale 1ns/1ps
module tb_alu_share_arbiter;
`ifdef ALU_ARB_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic [1:0]  s_v    = '0;
    logic [1:0]  s_rrdy = '0;
    logic [1:0]  s_f7   = '0;
    logic [4:0]  s_opc [2];
    logic [2:0]  s_f3  [2];
    logic [31:0] s_op1 [2];
    logic [31:0] s_op2 [2];
    logic        use_p = 1'b0;

    // Reference RV32I ALU: {branch, result}.
    function automatic logic [32:0] alu_ref(input logic [4:0] opc, input logic [2:0] f3,
                                            input logic f7, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] r;
        logic        br;
        r  = a + b;
        br = 1'b0;
        case (opc)
            5'b01100, 5'b00100: begin
                case (f3)
                    3'b000:  r = (opc == 5'b01100 && f7) ? a - b : a + b;
                    3'b001:  r = a << b[4:0];
                    3'b010:  r = {31'd0, ($signed(a) < $signed(b))};
                    3'b011:  r = {31'd0, (a < b)};
                    3'b100:  r = a ^ b;
                    3'b101:  r = f7 ? $signed(a) >>> b[4:0] : a >> b[4:0];
                    3'b110:  r = a | b;
                    default: r = a & b;
                endcase
            end
            5'b11000: begin
                r = 32'd0;
                case (f3)
                    3'b000:  br = (a == b);
                    3'b001:  br = (a != b);
                    3'b100:  br = ($signed(a) < $signed(b));
                    3'b101:  br = ($signed(a) >= $signed(b));
                    3'b110:  br = (a < b);
                    3'b111:  br = (a >= b);
                    default: br = 1'b0;
                endcase
            end
            5'b01101: r = b;
            default:  r = a + b;
        endcase
        return {br, r};
    endfunction

    alu_share_arbiter_if #(.DATA_W(32)) bus_f ();
    alu_share_arbiter_if #(.DATA_W(32)) bus_p ();

    alu_share_arbiter #(.DATA_W(32), .FAIR(1'b1)) dut_f (.clk(clk), .rst_n(rst_n), .bus(bus_f));
    alu_share_arbiter #(.DATA_W(32), .FAIR(1'b0)) dut_p (.clk(clk), .rst_n(rst_n), .bus(bus_p));

    assign bus_f.req0_valid  = s_v[0];    assign bus_p.req0_valid  = s_v[0];
    assign bus_f.req0_opcode = s_opc[0];  assign bus_p.req0_opcode = s_opc[0];
    assign bus_f.req0_func3  = s_f3[0];   assign bus_p.req0_func3  = s_f3[0];
    assign bus_f.req0_func7  = s_f7[0];   assign bus_p.req0_func7  = s_f7[0];
    assign bus_f.req0_op1    = s_op1[0];  assign bus_p.req0_op1    = s_op1[0];
    assign bus_f.req0_op2    = s_op2[0];  assign bus_p.req0_op2    = s_op2[0];
    assign bus_f.req1_valid  = s_v[1];    assign bus_p.req1_valid  = s_v[1];
    assign bus_f.req1_opcode = s_opc[1];  assign bus_p.req1_opcode = s_opc[1];
    assign bus_f.req1_func3  = s_f3[1];   assign bus_p.req1_func3  = s_f3[1];
    assign bus_f.req1_func7  = s_f7[1];   assign bus_p.req1_func7  = s_f7[1];
    assign bus_f.req1_op1    = s_op1[1];  assign bus_p.req1_op1    = s_op1[1];
    assign bus_f.req1_op2    = s_op2[1];  assign bus_p.req1_op2    = s_op2[1];
    assign bus_f.rsp0_ready  = s_rrdy[0]; assign bus_p.rsp0_ready  = s_rrdy[0];
    assign bus_f.rsp1_ready  = s_rrdy[1]; assign bus_p.rsp1_ready  = s_rrdy[1];

    logic [32:0] alu_f;
    logic [32:0] alu_p;
    assign alu_f = alu_ref(bus_f.alu_opcode, bus_f.alu_func3, bus_f.alu_func7, bus_f.alu_op1,
                           bus_f.alu_op2);
    assign alu_p = alu_ref(bus_p.alu_opcode, bus_p.alu_func3, bus_p.alu_func7, bus_p.alu_op1,
                           bus_p.alu_op2);
    assign bus_f.alu_result = alu_f[31:0];
    assign bus_f.alu_branch = alu_f[32];
    assign bus_p.alu_result = alu_p[31:0];
    assign bus_p.alu_branch = alu_p[32];

    logic [1:0]  o_rdy, o_rv, o_rb;
    logic [31:0] o_rd [2];
    logic [31:0] o_aop1, o_aop2;
    logic [4:0]  o_aopc;
    assign o_rdy  = use_p ? {bus_p.req1_ready, bus_p.req0_ready}
                          : {bus_f.req1_ready, bus_f.req0_ready};
    assign o_rv   = use_p ? {bus_p.rsp1_valid, bus_p.rsp0_valid}
                          : {bus_f.rsp1_valid, bus_f.rsp0_valid};
    assign o_rb   = use_p ? {bus_p.rsp1_branch, bus_p.rsp0_branch}
                          : {bus_f.rsp1_branch, bus_f.rsp0_branch};
    assign o_rd[0] = use_p ? bus_p.rsp0_data : bus_f.rsp0_data;
    assign o_rd[1] = use_p ? bus_p.rsp1_data : bus_f.rsp1_data;
    assign o_aop1 = use_p ? bus_p.alu_op1 : bus_f.alu_op1;
    assign o_aop2 = use_p ? bus_p.alu_op2 : bus_f.alu_op2;
    assign o_aopc = use_p ? bus_p.alu_opcode : bus_f.alu_opcode;

    task automatic clear_inputs();
        s_v = '0;
        s_rrdy = '0;
        s_f7 = '0;
        for (int i = 0; i < 2; i++) begin
            s_opc[i] = '0; s_f3[i] = '0; s_op1[i] = '0; s_op2[i] = '0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_payload(input int n, input logic [4:0] opc, input logic [2:0] f3,
                               input logic f7, input logic [31:0] a, input logic [31:0] b);
        s_opc[n] = opc; s_f3[n] = f3; s_f7[n] = f7; s_op1[n] = a; s_op2[n] = b;
    endtask

    task automatic rand_payload(input int n);
        int sel;
        sel = int'($urandom_range(0, 4));
        case (sel)
            0:       s_opc[n] = 5'b01100;
            1:       s_opc[n] = 5'b00100;
            2:       s_opc[n] = 5'b11000;
            3:       s_opc[n] = 5'b01101;
            default: s_opc[n] = 5'b00101;
        endcase
        s_f3[n]  = 3'($urandom_range(0, 7));
        s_f7[n]  = 1'($urandom_range(0, 1));
        s_op1[n] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
        s_op2[n] = ($urandom_range(0, 3) == 0) ? s_op1[n] : $urandom;
    endtask

    // Raise valid on port n and wait (bounded) until its ready is seen; returns in cycle T.
    task automatic issue(input int n, output bit ok);
        s_v[n] = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            #1;
            if (o_rdy[n]) ok = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic test_reset();
        use_p = 1'b0;
        rst_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        #1;
        n_chk++;
        if ({o_rv, o_rb} !== 4'b0) begin
            n_err++; $display("FAIL reset_rsp_flags: got %b want 0000", {o_rv, o_rb});
        end
        n_chk++;
        if (o_rd[0] !== 32'd0 || o_rd[1] !== 32'd0) begin
            n_err++; $display("FAIL reset_rsp_data: got %h/%h want 0/0", o_rd[0], o_rd[1]);
        end
        n_chk++;
        if (o_aop1 !== 32'd0 || o_aop2 !== 32'd0 || o_aopc !== 5'd0) begin
            n_err++;
            $display("FAIL reset_alu_regs: got %h %h %h want 0", o_aop1, o_aop2, o_aopc);
        end
        @(negedge clk);
        rst_n = 1'b1;
        s_v = 2'b10;
        #1;
        n_chk++;
        if (o_rdy !== 2'b10) begin
            n_err++; $display("FAIL reset_ready_sole_req1: got %b want 10", o_rdy);
        end
        s_v = 2'b11;
        #1;
        n_chk++;
        if (o_rdy !== 2'b01) begin
            n_err++; $display("FAIL reset_tie_req0: got %b want 01", o_rdy);
        end
        s_v = 2'b00;
    endtask

    task automatic test_add();
        bit ok;
        do_reset();
        use_p = 1'b0;
        s_rrdy = 2'b11;
        set_payload(0, 5'b01100, 3'b000, 1'b0, 32'd5, 32'd7);
        issue(0, ok);
        n_chk++;
        if (!ok) begin n_err++; $display("FAIL add_accept: got ready=0 want 1"); end
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            if (k == 1) s_v[0] = 1'b0;
            #1;
            if (k == 1) begin
                n_chk++;
                if (o_aop1 !== 32'd5 || o_aop2 !== 32'd7 || o_aopc !== 5'b01100) begin
                    n_err++;
                    $display("FAIL add_alu_inputs: got %h %h %b want 5 7 01100",
                             o_aop1, o_aop2, o_aopc);
                end
            end
            n_chk++;
            if (o_rv !== ((k == LAT) ? 2'b01 : 2'b00)) begin
                n_err++; $display("FAIL add_latency: cycle T+%0d got rsp_valid=%b", k, o_rv);
            end
        end
        n_chk++;
        if (o_rd[0] !== 32'd12 || o_rb[0] !== 1'b0) begin
            n_err++; $display("FAIL add_result: got %h/%b want 0000000c/0", o_rd[0], o_rb[0]);
        end
        @(negedge clk);
        #1;
        n_chk++;
        if (o_rv !== 2'b00) begin
            n_err++; $display("FAIL add_consumed: got rsp_valid=%b want 00", o_rv);
        end
    endtask

    task automatic test_branch();
        bit ok;
        logic [2:0] f3s [2];
        logic       want [2];
        f3s[0] = 3'b100; want[0] = 1'b1;
        f3s[1] = 3'b110; want[1] = 1'b0;
        do_reset();
        use_p = 1'b0;
        s_rrdy = 2'b11;
        for (int t = 0; t < 2; t++) begin
            set_payload(1, 5'b11000, f3s[t], 1'b0, 32'hFFFF_FFFF, 32'd1);
            issue(1, ok);
            n_chk++;
            if (!ok) begin n_err++; $display("FAIL br_accept: case %0d got ready=0 want 1", t); end
            for (int k = 1; k <= LAT; k++) begin
                @(negedge clk);
                if (k == 1) s_v[1] = 1'b0;
            end
            #1;
            n_chk++;
            if (o_rv !== 2'b10) begin
                n_err++; $display("FAIL br_valid: case %0d got %b want 10", t, o_rv);
            end
            n_chk++;
            if (o_rb[1] !== want[t]) begin
                n_err++; $display("FAIL br_flag: func3=%b got %b want %b", f3s[t], o_rb[1], want[t]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        bit ok;
        int n, d;
        logic [32:0] exp;
        do_reset();
        use_p = 1'b0;
        for (int i = 0; i < 20; i++) begin
            n = int'($urandom_range(0, 1));
            rand_payload(n);
            exp = alu_ref(s_opc[n], s_f3[n], s_f7[n], s_op1[n], s_op2[n]);
            s_rrdy = 2'b00;
            issue(n, ok);
            n_chk++;
            if (!ok) begin n_err++; $display("FAIL rnd_accept: port %0d got ready=0 want 1", n); end
            for (int k = 1; k <= LAT; k++) begin
                @(negedge clk);
                if (k == 1) s_v[n] = 1'b0;
            end
            d = int'($urandom_range(0, 2));
            for (int k = 0; k <= d; k++) begin
                #1;
                n_chk++;
                if (o_rv !== (2'b01 << n) || o_rd[n] !== exp[31:0] || o_rb[n] !== exp[32]) begin
                    n_err++;
                    $display("FAIL rnd_rsp: op %0d port %0d got v=%b d=%h b=%b want d=%h b=%b",
                             i, n, o_rv, o_rd[n], o_rb[n], exp[31:0], exp[32]);
                end
                if (k < d) @(negedge clk);
            end
            s_rrdy[n] = 1'b1;
            @(negedge clk);
            s_rrdy = 2'b00;
            #1;
            n_chk++;
            if (o_rv !== 2'b00) begin
                n_err++; $display("FAIL rnd_consumed: got %b want 00", o_rv);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [32:0] q0[$];
        logic [32:0] q1[$];
        logic [32:0] exp;
        int grants, exp_g, last_hs, g, pend_n;
        bit pend;
        do_reset();
        use_p = 1'b0;
        s_rrdy = 2'b11;
        rand_payload(0);
        rand_payload(1);
        s_v = 2'b11;
        exp_g = 0; grants = 0; last_hs = -1; pend = 1'b0; pend_n = 0;
        for (int cyc = 0; cyc < 80 && grants < 8; cyc++) begin
            if (pend) begin rand_payload(pend_n); pend = 1'b0; end
            #1;
            if (o_rv != 2'b00) begin
                n_chk++;
                if (o_rdy !== 2'b00 || o_rv === 2'b11) begin
                    n_err++; $display("FAIL rr_busy: got rdy=%b rv=%b want rdy=00", o_rdy, o_rv);
                end
                exp = 33'h0;
                if (o_rv[1] && q1.size() > 0) exp = q1.pop_front();
                else if (o_rv[0] && q0.size() > 0) exp = q0.pop_front();
                n_chk++;
                if (o_rd[o_rv[1]] !== exp[31:0] || o_rb[o_rv[1]] !== exp[32]) begin
                    n_err++;
                    $display("FAIL rr_rsp: port %0d got %h/%b want %h/%b", o_rv[1],
                             o_rd[o_rv[1]], o_rb[o_rv[1]], exp[31:0], exp[32]);
                end
            end
            if (o_rdy != 2'b00) begin
                g = int'(o_rdy[1]);
                n_chk++;
                if (g != exp_g) begin
                    n_err++; $display("FAIL rr_grant: grant %0d got req%0d want req%0d", grants, g, exp_g);
                end
                if (last_hs >= 0) begin
                    n_chk++;
                    if (cyc - last_hs != LAT + 1) begin
                        n_err++;
                        $display("FAIL rr_throughput: got gap %0d want %0d", cyc - last_hs, LAT + 1);
                    end
                end
                if (g == 0) q0.push_back(alu_ref(s_opc[0], s_f3[0], s_f7[0], s_op1[0], s_op2[0]));
                else        q1.push_back(alu_ref(s_opc[1], s_f3[1], s_f7[1], s_op1[1], s_op2[1]));
                exp_g = 1 - g;
                last_hs = cyc;
                grants++;
                pend = 1'b1;
                pend_n = g;
            end
            @(negedge clk);
        end
        s_v = 2'b00;
        n_chk++;
        if (grants != 8) begin n_err++; $display("FAIL rr_grant_count: got %0d want 8", grants); end
        for (int cyc = 0; cyc < 6; cyc++) begin
            #1;
            if (o_rv[0] && q0.size() > 0) begin
                exp = q0.pop_front();
                n_chk++;
                if (o_rd[0] !== exp[31:0]) begin
                    n_err++; $display("FAIL rr_drain0: got %h want %h", o_rd[0], exp[31:0]);
                end
            end
            if (o_rv[1] && q1.size() > 0) begin
                exp = q1.pop_front();
                n_chk++;
                if (o_rd[1] !== exp[31:0]) begin
                    n_err++; $display("FAIL rr_drain1: got %h want %h", o_rd[1], exp[31:0]);
                end
            end
            @(negedge clk);
        end
        n_chk++;
        if (q0.size() + q1.size() != 0) begin
            n_err++; $display("FAIL rr_all_responses: got %0d outstanding want 0", q0.size() + q1.size());
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [32:0] exp1, exp0;
        do_reset();
        use_p = 1'b0;
        s_rrdy = 2'b00;
        rand_payload(1);
        exp1 = alu_ref(s_opc[1], s_f3[1], s_f7[1], s_op1[1], s_op2[1]);
        issue(1, ok);
        n_chk++;
        if (!ok) begin n_err++; $display("FAIL bp_accept1: got ready=0 want 1"); end
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            if (k == 1) begin
                s_v[1] = 1'b0;
                rand_payload(0);
                exp0 = alu_ref(s_opc[0], s_f3[0], s_f7[0], s_op1[0], s_op2[0]);
                s_v[0] = 1'b1;
            end
            #1;
            n_chk++;
            if (o_rdy !== 2'b00) begin
                n_err++; $display("FAIL bp_ready_low: got %b want 00", o_rdy);
            end
        end
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin @(negedge clk); #1; end
            n_chk++;
            if (o_rv !== 2'b10 || o_rd[1] !== exp1[31:0] || o_rb[1] !== exp1[32] || o_rdy !== 2'b00)
            begin
                n_err++;
                $display("FAIL bp_hold: got v=%b d=%h b=%b rdy=%b want v=10 d=%h b=%b rdy=00",
                         o_rv, o_rd[1], o_rb[1], o_rdy, exp1[31:0], exp1[32]);
            end
        end
        s_rrdy[1] = 1'b1;
        #1;
        n_chk++;
        if (o_rdy !== 2'b00) begin
            n_err++; $display("FAIL bp_ready_at_consume: got %b want 00", o_rdy);
        end
        @(negedge clk);
        s_rrdy = 2'b01;
        #1;
        n_chk++;
        if (o_rv !== 2'b00 || o_rdy !== 2'b01) begin
            n_err++; $display("FAIL bp_req0_accept: got v=%b rdy=%b want 00/01", o_rv, o_rdy);
        end
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            if (k == 1) s_v[0] = 1'b0;
        end
        #1;
        n_chk++;
        if (o_rv !== 2'b01 || o_rd[0] !== exp0[31:0] || o_rb[0] !== exp0[32]) begin
            n_err++;
            $display("FAIL bp_rsp0: got v=%b d=%h want 01 %h", o_rv, o_rd[0], exp0[31:0]);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        use_p = 1'b0;
        s_rrdy = 2'b11;
        set_payload(0, 5'b01100, 3'b000, 1'b0, 32'd1, 32'd2);
        issue(0, ok);
        n_chk++;
        if (!ok) begin n_err++; $display("FAIL rst_mid_accept: got ready=0 want 1"); end
        @(negedge clk);
        s_v[0] = 1'b0;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (o_rv !== 2'b00) begin n_err++; $display("FAIL rst_mid_clear: got %b want 00", o_rv); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_chk++;
            if (o_rv !== 2'b00) begin
                n_err++; $display("FAIL rst_mid_no_rsp: cycle %0d got %b want 00", k, o_rv);
            end
            @(negedge clk);
        end
        s_v = 2'b11;
        #1;
        n_chk++;
        if (o_rdy !== 2'b01) begin
            n_err++; $display("FAIL rst_mid_tie_req0: got %b want 01", o_rdy);
        end
        s_v = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_fixed_priority();
        logic [32:0] q0[$];
        logic [32:0] exp;
        int n0;
        bit pend;
        do_reset();
        use_p = 1'b1;
        s_rrdy = 2'b11;
        rand_payload(0);
        rand_payload(1);
        s_v = 2'b11;
        n0 = 0;
        pend = 1'b0;
        for (int cyc = 0; cyc < 40 && n0 < 3; cyc++) begin
            if (pend) begin rand_payload(0); pend = 1'b0; end
            #1;
            if (o_rv != 2'b00) begin
                exp = (q0.size() > 0) ? q0.pop_front() : 33'h0;
                n_chk++;
                if (o_rv !== 2'b01 || o_rd[0] !== exp[31:0] || o_rb[0] !== exp[32]) begin
                    n_err++;
                    $display("FAIL fp_rsp: got v=%b d=%h want 01 %h", o_rv, o_rd[0], exp[31:0]);
                end
            end
            if (o_rdy != 2'b00) begin
                n_chk++;
                if (o_rdy !== 2'b01) begin
                    n_err++; $display("FAIL fp_grant_req0: op %0d got %b want 01", n0, o_rdy);
                end
                q0.push_back(alu_ref(s_opc[0], s_f3[0], s_f7[0], s_op1[0], s_op2[0]));
                n0++;
                pend = 1'b1;
            end
            @(negedge clk);
        end
        s_v[0] = 1'b0;
        for (int k = 0; k < 10 && o_rdy == 2'b00; k++) begin
            #1;
            if (o_rv[0] && q0.size() > 0) begin
                exp = q0.pop_front();
                n_chk++;
                if (o_rd[0] !== exp[31:0]) begin
                    n_err++; $display("FAIL fp_last_rsp: got %h want %h", o_rd[0], exp[31:0]);
                end
            end
            if (o_rdy == 2'b00) @(negedge clk);
        end
        #1;
        n_chk++;
        if (o_rdy !== 2'b10) begin
            n_err++; $display("FAIL fp_req1_after_drop: got %b want 10", o_rdy);
        end
        n_chk++;
        if (q0.size() != 0 || n0 != 3) begin
            n_err++; $display("FAIL fp_req0_ops: got %0d grants %0d pending want 3/0", n0, q0.size());
        end
        s_v = 2'b00;
        @(negedge clk);
    endtask

    initial begin
        clear_inputs();
        @(negedge clk);
        test_reset();
        test_add();
        test_branch();
        test_random();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_fixed_priority();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish want finish before 300us");
        $fatal(1, "watchdog");
    end
endmodule
